// File: rtl/sram_bit_ctrl.sv
// Sequencer for an array of single-bit SRAM cells: a valid/ready request port on one side
// and the per-cell write enable / word line strobes on the other, with every output registered.
module sram_bit_ctrl #(
    parameter int ADDR_W    = 4,
    localparam int DEPTH    = 2**ADDR_W,
    parameter int RD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_rdata,
    output logic [DEPTH-1:0]  cell_write_en,
    output logic              cell_wb,
    output logic              cell_data_in,
    output logic [DEPTH-1:0]  cell_wl,
    output logic              cell_blb,
    input  logic              cell_data_out
);

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        RD_WL,
        RSP
    } state_t;

    localparam int CNT_W = (RD_CYCLES > 1) ? $clog2(RD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_CYCLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;

    function automatic logic [DEPTH-1:0] onehot(input logic [ADDR_W-1:0] a);
        logic [DEPTH-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    // Outputs are assigned on the edge that enters each state, so they are valid for that whole state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            addr_q        <= '0;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= 1'b0;
            cell_write_en <= '0;
            cell_wb       <= 1'b0;
            cell_data_in  <= 1'b0;
            cell_wl       <= '0;
            cell_blb      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        addr_q    <= req_addr;
                        if (req_we) begin
                            state        <= WR_SETUP;
                            cell_wb      <= 1'b1;
                            cell_data_in <= req_wdata;
                        end else begin
                            state    <= RD_WL;
                            cnt      <= CNT_LOAD;
                            cell_wl  <= onehot(req_addr);
                            cell_blb <= 1'b0;
                        end
                    end
                end
                WR_SETUP: begin
                    state         <= WR_PULSE;
                    cell_write_en <= onehot(addr_q);
                end
                WR_PULSE: begin
                    state         <= WR_HOLD;
                    cell_write_en <= '0;
                end
                WR_HOLD: begin
                    state        <= RSP;
                    cell_wb      <= 1'b0;
                    cell_data_in <= 1'b0;
                    rsp_valid    <= 1'b1;
                    rsp_rdata    <= 1'b0;
                end
                // The word line has been up for RD_CYCLES cycles when the counter reaches zero.
                RD_WL: begin
                    if (cnt == '0) begin
                        state     <= RSP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= cell_data_out;
                        cell_wl   <= '0;
                        cell_blb  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_bit_ctrl.sv
// Self-checking bench for sram_bit_ctrl: a behavioural cell array answers the strobes and a
// plain memory array predicts every read.
module tb_sram_bit_ctrl;

    localparam int ADDR_W    = 4;
    localparam int DEPTH     = 2**ADDR_W;
    localparam int RD_CYCLES = 2;

    logic              clk;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic              req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_rdata;
    logic [DEPTH-1:0]  cell_write_en;
    logic              cell_wb;
    logic              cell_data_in;
    logic [DEPTH-1:0]  cell_wl;
    logic              cell_blb;
    logic              cell_data_out;

    int assert_count;
    int fail_count;

    logic cells   [DEPTH];
    logic ref_mem [DEPTH];
    bit   known   [DEPTH];
    int   we_cnt  [DEPTH];
    int   snap    [DEPTH];

    sram_bit_ctrl #(
        .ADDR_W   (ADDR_W),
        .RD_CYCLES(RD_CYCLES)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .cell_write_en(cell_write_en),
        .cell_wb      (cell_wb),
        .cell_data_in (cell_data_in),
        .cell_wl      (cell_wl),
        .cell_blb     (cell_blb),
        .cell_data_out(cell_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Cell array: a cell takes the data line when its write enable is up with the write strobe,
    // and drives the read line only while its word line is up and bit-line-bar is low.
    always @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++)
            if (cell_write_en[i] && cell_wb) cells[i] <= cell_data_in;
    end

    always_comb begin
        cell_data_out = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (cell_wl[i] && !cell_blb) cell_data_out = cells[i];
    end

    always @(negedge clk) begin
        checkOutput("wl_we_exclusive", {31'b0, (|cell_wl) && (|cell_write_en)}, 32'd0);
        checkOutput("wl_onehot", {31'b0, $countones(cell_wl) <= 1}, 32'd1);
        checkOutput("we_onehot", {31'b0, $countones(cell_write_en) <= 1}, 32'd1);
        for (int i = 0; i < DEPTH; i++)
            if (cell_write_en[i]) we_cnt[i]++;
    end

    function automatic logic [31:0] we_changed();
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < DEPTH; i++)
            if (we_cnt[i] != snap[i]) m[i] = 1'b1;
        return m;
    endfunction

    // One full transaction starting just after a clock edge; bp is the number of RSP edges
    // spent with rsp_ready low while extra req_valid pulses are thrown at the port.
    task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] addr, input logic wdata,
                                 input int bp, output logic rdata);
        int waits;
        int lat;
        logic [31:0] sel;
        waits = 0;
        while (!req_ready && waits < 20) begin
            @(posedge clk); #1;
            waits++;
        end
        checkOutput("req_ready_before_req", {31'b0, req_ready}, 32'd1);
        rsp_ready = (bp == 0);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = ADDR_W'($urandom);
        req_wdata = 1'($urandom_range(0, 1));
        checkOutput("accepted", {31'b0, req_ready}, 32'd0);
        sel = 32'd1 << addr;
        if (we) begin
            checkOutput("wr_setup_wb", {31'b0, cell_wb}, 32'd1);
            checkOutput("wr_setup_data", {31'b0, cell_data_in}, {31'b0, wdata});
            checkOutput("wr_setup_quiet", {cell_wl, cell_write_en}, 32'd0);
        end else begin
            checkOutput("rd_wl_sel", {16'b0, cell_wl}, sel);
            checkOutput("rd_blb_low", {31'b0, cell_blb}, 32'd0);
        end
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput(we ? "wr_latency" : "rd_latency", lat, we ? 32'd3 : RD_CYCLES);
        checkOutput("rsp_wl_released", {16'b0, cell_wl}, 32'd0);
        checkOutput("rsp_blb_high", {31'b0, cell_blb}, 32'd1);
        rdata = rsp_rdata;
        for (int i = 0; i < bp; i++) begin
            req_valid = 1'b1;
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = ADDR_W'($urandom);
            @(posedge clk); #1;
            checkOutput("bp_valid", {31'b0, rsp_valid}, 32'd1);
            checkOutput("bp_rdata", {31'b0, rsp_rdata}, {31'b0, rdata});
            checkOutput("bp_req_ready", {31'b0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle_after_rsp", {30'b0, rsp_valid, req_ready}, 32'd1);
        checkOutput("idle_bus", {29'b0, cell_blb, cell_wb, cell_data_in}, 32'd4);
        checkOutput("idle_strobes", {cell_wl, cell_write_en}, 32'd0);
    endtask

    initial begin
        logic r;
        logic [ADDR_W-1:0] wa;
        logic [ADDR_W-1:0] ra;
        logic wd;
        assert_count = 0;
        fail_count   = 0;
        reset_n   = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = 1'b0;
        rsp_ready = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        checkOutput("reset_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("reset_rsp", {30'b0, rsp_valid, rsp_rdata}, 32'd0);
        checkOutput("reset_bus", {29'b0, cell_blb, cell_wb, cell_data_in}, 32'd4);
        checkOutput("reset_strobes", {cell_wl, cell_write_en}, 32'd0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;

        // Write then read the same cell.
        applyStimulus(1'b1, 4'd5, 1'b1, 0, r);
        checkOutput("wr5_rdata", {31'b0, r}, 32'd0);
        ref_mem[5] = 1'b1; known[5] = 1'b1;
        applyStimulus(1'b0, 4'd5, 1'b0, 0, r);
        checkOutput("rd5_rdata", {31'b0, r}, 32'd1);

        // Cell isolation.
        snap = we_cnt;
        applyStimulus(1'b1, 4'd3, 1'b1, 0, r);
        checkOutput("iso_we_mask3", we_changed(), 32'd1 << 3);
        ref_mem[3] = 1'b1; known[3] = 1'b1;
        snap = we_cnt;
        applyStimulus(1'b1, 4'd4, 1'b0, 0, r);
        checkOutput("iso_we_mask4", we_changed(), 32'd1 << 4);
        ref_mem[4] = 1'b0; known[4] = 1'b1;
        applyStimulus(1'b0, 4'd3, 1'b0, 0, r);
        checkOutput("iso_rd3", {31'b0, r}, {31'b0, ref_mem[3]});
        applyStimulus(1'b0, 4'd4, 1'b0, 0, r);
        checkOutput("iso_rd4", {31'b0, r}, {31'b0, ref_mem[4]});

        // Backpressure on both a read and a write response.
        applyStimulus(1'b0, 4'd3, 1'b0, 5, r);
        checkOutput("bp_rd3", {31'b0, r}, {31'b0, ref_mem[3]});
        applyStimulus(1'b1, 4'd7, 1'b1, 5, r);
        checkOutput("bp_wr7", {31'b0, r}, 32'd0);
        ref_mem[7] = 1'b1; known[7] = 1'b1;

        // Random write/read streaming against the reference memory.
        for (int i = 0; i < 16; i++) begin
            wa = ADDR_W'($urandom);
            wd = 1'($urandom_range(0, 1));
            applyStimulus(1'b1, wa, wd, 0, r);
            checkOutput("stream_wr_rdata", {31'b0, r}, 32'd0);
            ref_mem[wa] = wd; known[wa] = 1'b1;
            ra = ADDR_W'($urandom);
            if (!known[ra]) ra = wa;
            applyStimulus(1'b0, ra, 1'b0, 0, r);
            checkOutput("stream_rd", {31'b0, r}, {31'b0, ref_mem[ra]});
        end

        // Reset landing in the middle of a read.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd6;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checkOutput("mid_rd_wl", {16'b0, cell_wl}, 32'd1 << 6);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst_async_wl", {16'b0, cell_wl}, 32'd0);
        checkOutput("rst_async_blb", {31'b0, cell_blb}, 32'd1);
        checkOutput("rst_async_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("rst_async_rsp", {31'b0, rsp_valid}, 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("no_rsp_in_reset", {31'b0, rsp_valid}, 32'd0);
        end
        reset_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            checkOutput("no_rsp_after_reset", {31'b0, rsp_valid}, 32'd0);
            checkOutput("ready_after_reset", {31'b0, req_ready}, 32'd1);
        end
        applyStimulus(1'b0, 4'd5, 1'b0, 0, r);
        checkOutput("rd5_after_reset", {31'b0, r}, {31'b0, ref_mem[5]});

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/sram_bit_ctrl.md
SRAM_BIT_CTRL -- requirements
Module: sram_bit_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 4, cell address width.
REQ-002 Parameter: DEPTH, fixed at 2**ADDR_W, number of attached single-bit cells.
REQ-003 Parameter: RD_CYCLES, default 2, minimum 1, number of cycles the word line is held before sampling.
REQ-004 Port: clk  in  1  sole clock, rising edge.
REQ-005 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-006 Port: req_valid  in  1  request present.
REQ-007 Port: req_ready  out  1  controller can accept a request.
REQ-008 Port: req_we  in  1  1 = write, 0 = read.
REQ-009 Port: req_addr  in  ADDR_W  target cell.
REQ-010 Port: req_wdata  in  1  write data.
REQ-011 Port: rsp_valid  out  1  response present.
REQ-012 Port: rsp_ready  in  1  response consumer ready.
REQ-013 Port: rsp_rdata  out  1  read data; 0 for write responses.
REQ-014 Port: cell_write_en  out  DEPTH  per-cell write enable, one-hot or zero.
REQ-015 Port: cell_wb  out  1  shared write-bit strobe.
REQ-016 Port: cell_data_in  out  1  shared write data line.
REQ-017 Port: cell_wl  out  DEPTH  per-cell word line, one-hot or zero.
REQ-018 Port: cell_blb  out  1  shared bit-line-bar; 0 enables the selected cell's output.
REQ-019 Port: cell_data_out  in  1  shared tri-state read bit line.

Function
REQ-020 All outputs SHALL be driven from registers; no combinational path from any input to any output.
REQ-021 States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_WL, RSP.
REQ-022 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid && req_ready, latching req_we, req_addr, and req_wdata.
REQ-023 Transitions on accept: req_we=1 goes to WR_SETUP; req_we=0 goes to RD_WL with the word-line counter loaded to RD_CYCLES-1.
REQ-024 WR_SETUP (1 cycle): cell_data_in=latched data, cell_wb=1, cell_write_en=0, cell_wl=0; next state WR_PULSE.
REQ-025 WR_PULSE (1 cycle): cell_write_en[addr]=1, with cell_wb and cell_data_in held; next state WR_HOLD.
REQ-026 WR_HOLD (1 cycle): cell_write_en=0, with cell_wb and cell_data_in still held; next state RSP with rsp_rdata=0.
REQ-027 RD_WL: cell_wl[addr]=1, cell_blb=0, cell_wb=0, cell_write_en=0; the counter decrements each cycle.
REQ-028 In RD_WL, on the edge where the counter is 0, cell_data_out SHALL be sampled into rsp_rdata and the next state is RSP.
REQ-029 On leaving RD_WL, cell_wl SHALL return to 0 and cell_blb to 1 in the same cycle that rsp_valid rises.
REQ-030 Latency: rsp_valid rises 3 edges after a write accept and RD_CYCLES edges after a read accept.
REQ-031 RSP: rsp_valid=1 and rsp_rdata stable until an edge with rsp_ready=1; then the next state is IDLE.
REQ-032 A new request SHALL NOT be accepted in the cycle the response handshake completes; there is at most one outstanding request.
REQ-033 cell_wl and cell_write_en SHALL never both be nonzero in the same cycle.
REQ-034 Idle bus levels: cell_blb=1, cell_wb=0, cell_data_in=0, cell_wl=0, cell_write_en=0.
REQ-035 req_* inputs are ignored outside IDLE.
REQ-036 rsp_ready held 1 SHALL give back-to-back operations with exactly one IDLE cycle between them.

Reset
REQ-037 reset_n=0 SHALL immediately force, regardless of clk:
- state IDLE and counter 0;
- req_ready=1, rsp_valid=0, rsp_rdata=0;
- the idle bus levels of REQ-034.
REQ-038 A reset asserted mid-operation SHALL abandon the operation with no response; if it lands in WR_PULSE the cell content is undefined.
REQ-039 The first accept after reset_n rises SHALL occur no earlier than the first rising edge with reset_n=1.

Verification
REQ-040 Write then read: write addr 5 data 1, then read addr 5, with RD_CYCLES=2.
- rsp_valid 3 edges after the write accept, rsp_rdata=0.
- rsp_valid 2 edges after the read accept, rsp_rdata=1.
REQ-041 Cell isolation: write addr 3 data 1 and addr 4 data 0, then read both.
- Reads return 1 and 0.
- Only bit 3, then only bit 4, of cell_write_en was ever set.
REQ-042 Backpressure: hold rsp_ready=0 for 5 cycles during RSP.
- rsp_valid and rsp_rdata stay stable.
- req_ready stays 0; req_valid pulses are ignored.
REQ-043 Reset mid-operation: assert reset_n=0 during RD_WL.
- cell_wl=0, cell_blb=1, and req_ready=1 without waiting for a clk edge.
- No rsp_valid ever appears for that read.
REQ-044 Streaming: 16 random write/read pairs with rsp_ready=1 and a reference model.
- All read data matches the model.
- Exactly one IDLE cycle between operations.
- Assertion of REQ-033 holds every cycle.
